// File: rtl/bp_fe_pc_gen_ctrl.sv
// bp_fe_pc_gen_ctrl: front-end fetch PC sequencing with redirect, miss replay and prediction
module bp_fe_pc_gen_ctrl #(
  parameter int eaddr_width_p = 64,
  parameter logic [eaddr_width_p-1:0] first_pc_p = 'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  input  logic                     cmd_redirect_i,
  input  logic [eaddr_width_p-1:0] cmd_pc_i,
  output logic                     cmd_ready_o,
  input  logic                     pred_v_i,
  input  logic [eaddr_width_p-1:0] pred_pc_i,
  output logic                     icache_v_o,
  output logic [eaddr_width_p-1:0] icache_pc_o,
  input  logic                     icache_ready_i,
  input  logic                     icache_resp_v_i,
  input  logic                     icache_miss_i,
  input  logic                     fe_queue_ready_i,
  output logic                     fetch_v_o,
  output logic [eaddr_width_p-1:0] fetch_pc_o,
  output logic                     flush_o,
  output logic                     misaligned_o,
  output logic [1:0]               state_o
);
  localparam logic [1:0] run_s  = 2'd0;
  localparam logic [1:0] wait_s = 2'd1;
  localparam logic [1:0] halt_s = 2'd2;
  localparam logic [eaddr_width_p-1:0] four = 4;
  logic [1:0] state_r;
  logic [eaddr_width_p-1:0] pc_r, if2_pc_r, pend_pc_r, issue_pc;
  logic if2_v_r, redirect, misalign, miss, live, bp, req_v, fire;
  assign redirect = reset_i & cmd_v_i & cmd_redirect_i;
  assign misalign = redirect & (|cmd_pc_i[1:0]);
  assign miss     = if2_v_r & icache_miss_i & ~redirect;
  assign live     = if2_v_r & icache_resp_v_i & ~icache_miss_i & ~redirect;
  assign bp       = live & ~fe_queue_ready_i;
  assign issue_pc = (state_r == wait_s) ? pend_pc_r : (live & pred_v_i) ? pred_pc_i : pc_r;
  assign req_v    = reset_i & ~redirect &
                    ((state_r == wait_s) ? fe_queue_ready_i : ((state_r == run_s) & ~miss & ~bp));
  assign fire     = req_v & icache_ready_i;
  assign cmd_ready_o  = reset_i;
  assign icache_v_o   = req_v;
  assign icache_pc_o  = reset_i ? issue_pc : '0;
  assign fetch_v_o    = reset_i & live & fe_queue_ready_i;
  assign fetch_pc_o   = reset_i ? if2_pc_r : '0;
  assign flush_o      = reset_i & (redirect | miss | bp | ((state_r == halt_s) & icache_resp_v_i));
  assign misaligned_o = misalign;
  assign state_o      = reset_i ? state_r : 2'd0;
  // redirect beats miss/back-pressure; both of the latter replay the in-flight PC from WAIT
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= run_s;
      pc_r    <= first_pc_p;
      if2_v_r <= 1'b0;
    end else begin
      if2_v_r <= fire;
      if (fire) begin
        pc_r     <= issue_pc + four;
        if2_pc_r <= issue_pc;
      end
      if (redirect) begin
        state_r <= misalign ? halt_s : wait_s;
        if (!misalign) pend_pc_r <= cmd_pc_i;
      end else if (miss | bp) begin
        state_r   <= wait_s;
        pend_pc_r <= if2_pc_r;
      end else if (fire) begin
        state_r <= run_s;
      end
    end
  end
endmodule

// File: tb/tb_bp_fe_pc_gen_ctrl.sv
// tb_bp_fe_pc_gen_ctrl: scoreboard bench for the fetch PC controller
module tb_bp_fe_pc_gen_ctrl;
  localparam logic [63:0] B = 64'h8000_0000;
  localparam logic [63:0] NONE = 64'hffff_ffff_ffff_ffff;
  logic clk = 0;
  logic reset_i, cmd_v_i, cmd_redirect_i, cmd_ready_o, pred_v_i;
  logic [63:0] cmd_pc_i, pred_pc_i, icache_pc_o, fetch_pc_o;
  logic icache_v_o, icache_ready_i, icache_resp_v_i, icache_miss_i, fe_queue_ready_i;
  logic fetch_v_o, flush_o, misaligned_o;
  logic [1:0] state_o;
  logic [63:0] exp_req[$];
  logic [63:0] exp_fetch[$];
  logic fire, miss_arm;
  logic [63:0] last_pc, miss_pc;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bp_fe_pc_gen_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_redirect_i(cmd_redirect_i),
    .cmd_pc_i(cmd_pc_i), .cmd_ready_o(cmd_ready_o), .pred_v_i(pred_v_i), .pred_pc_i(pred_pc_i),
    .icache_v_o(icache_v_o), .icache_pc_o(icache_pc_o), .icache_ready_i(icache_ready_i),
    .icache_resp_v_i(icache_resp_v_i), .icache_miss_i(icache_miss_i),
    .fe_queue_ready_i(fe_queue_ready_i), .fetch_v_o(fetch_v_o), .fetch_pc_o(fetch_pc_o),
    .flush_o(flush_o), .misaligned_o(misaligned_o), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    fire = icache_v_o & icache_ready_i;
    last_pc = icache_pc_o;
    if (fire) check("req", icache_pc_o, exp_req.size() != 0 ? exp_req.pop_front() : NONE);
    if (fetch_v_o) check("fetch", fetch_pc_o, exp_fetch.size() != 0 ? exp_fetch.pop_front() : NONE);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    icache_resp_v_i = fire;
    icache_miss_i = fire & miss_arm & (last_pc == miss_pc);
    if (icache_miss_i) miss_arm = 0;
  endtask

  initial begin
    reset_i = 0; cmd_v_i = 1; cmd_redirect_i = 1; cmd_pc_i = B + 2;
    pred_v_i = 0; pred_pc_i = 0; icache_ready_i = 1; icache_resp_v_i = 0;
    icache_miss_i = 0; fe_queue_ready_i = 1; miss_arm = 0; miss_pc = 0; fire = 0; last_pc = 0;
    repeat (2) begin
      sample();
      check("rst_v", icache_v_o, 0); check("rst_mis", misaligned_o, 0);
      check("rst_flush", flush_o, 0); check("rst_rdy", cmd_ready_o, 0);
      check("rst_state", state_o, 0);
      tick();
    end
    cmd_v_i = 0; reset_i = 1;
    exp_req.push_back(B);
    sample(); check("c0_state", state_o, 0); check("c0_rdy", cmd_ready_o, 1); check("c0_v", icache_v_o, 1); tick();
    exp_req.push_back(B + 4); exp_fetch.push_back(B);
    sample(); check("c1_fv", fetch_v_o, 1); tick();
    exp_req.push_back(B + 8); exp_fetch.push_back(B + 4); miss_pc = B + 8; miss_arm = 1;
    sample(); tick();
    sample(); check("miss_flush", flush_o, 1); check("miss_fv", fetch_v_o, 0); check("miss_v", icache_v_o, 0); tick();
    icache_ready_i = 0;
    repeat (5) begin
      sample(); check("wait_state", state_o, 1); check("wait_flush", flush_o, 0); tick();
    end
    icache_ready_i = 1; exp_req.push_back(B + 8);
    sample(); check("replay_state", state_o, 1); tick();
    pred_v_i = 1; pred_pc_i = B + 64'h100; exp_fetch.push_back(B + 8); exp_req.push_back(B + 64'h100);
    sample(); check("pred_flush", flush_o, 0); check("pred_state", state_o, 0); tick();
    pred_v_i = 0; cmd_v_i = 1; cmd_redirect_i = 0; cmd_pc_i = B + 64'h4444;
    exp_fetch.push_back(B + 64'h100); exp_req.push_back(B + 64'h104);
    sample(); check("attaboy_rdy", cmd_ready_o, 1); check("attaboy_flush", flush_o, 0); tick();
    cmd_v_i = 0; exp_fetch.push_back(B + 64'h104); exp_req.push_back(B + 64'h108);
    miss_pc = B + 64'h108; miss_arm = 1;
    sample(); tick();
    cmd_v_i = 1; cmd_redirect_i = 1; cmd_pc_i = B + 64'h2000;
    sample(); check("rdmiss_flush", flush_o, 1); check("rdmiss_fv", fetch_v_o, 0); check("rdmiss_v", icache_v_o, 0); tick();
    cmd_v_i = 0; exp_req.push_back(B + 64'h2000);
    sample(); check("rd_state", state_o, 1); tick();
    exp_fetch.push_back(B + 64'h2000); exp_req.push_back(B + 64'h2004);
    sample(); tick();
    cmd_v_i = 1; cmd_pc_i = B + 64'h2002;
    sample(); check("mis_pulse", misaligned_o, 1); check("mis_flush", flush_o, 1); check("mis_v", icache_v_o, 0); tick();
    cmd_v_i = 0;
    repeat (2) begin
      sample(); check("halt_state", state_o, 2); check("halt_v", icache_v_o, 0); check("halt_mis", misaligned_o, 0); tick();
    end
    cmd_v_i = 1; cmd_pc_i = B + 64'h3000;
    sample(); check("unhalt_flush", flush_o, 1); check("unhalt_mis", misaligned_o, 0); check("unhalt_state", state_o, 2); tick();
    cmd_v_i = 0; exp_req.push_back(B + 64'h3000);
    sample(); check("unhalt_wait", state_o, 1); tick();
    exp_fetch.push_back(B + 64'h3000); exp_req.push_back(B + 64'h3004);
    sample(); tick();
    fe_queue_ready_i = 0;
    sample(); check("bp_flush", flush_o, 1); check("bp_fv", fetch_v_o, 0); check("bp_v", icache_v_o, 0); tick();
    sample(); check("bp_state", state_o, 1); check("bp_wait_v", icache_v_o, 0); tick();
    fe_queue_ready_i = 1; exp_req.push_back(B + 64'h3004);
    sample(); tick();
    exp_fetch.push_back(B + 64'h3004); exp_req.push_back(B + 64'h3008);
    miss_pc = B + 64'h3008; miss_arm = 1;
    sample(); tick();
    sample(); check("miss2_flush", flush_o, 1); tick();
    reset_i = 0; icache_resp_v_i = 1; icache_miss_i = 0;
    sample(); check("mrst_v", icache_v_o, 0); check("mrst_pc", icache_pc_o, 0);
    check("mrst_flush", flush_o, 0); check("mrst_state", state_o, 0); check("mrst_fv", fetch_v_o, 0); tick();
    reset_i = 1; icache_resp_v_i = 1; icache_miss_i = 0; exp_req.push_back(B);
    sample(); check("post_state", state_o, 0); check("post_fv", fetch_v_o, 0); tick();
    exp_fetch.push_back(B); exp_req.push_back(B + 4);
    sample(); tick();
    icache_ready_i = 0; exp_fetch.push_back(B + 4);
    sample(); tick();
    sample(); tick();
    check("req_left", exp_req.size(), 0);
    check("fetch_left", exp_fetch.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
